// File: rtl/aes_byte_scanner.sv
// aes_byte_scanner: latches a 128-bit AES result block and presents it
// one byte at a time for a 3-digit 7-segment display.
//
// Ports:
//   clk      - system clock, all state on rising edge
//   rst      - asynchronous active-low reset
//   load     - single-cycle strobe, captures block_in and starts a scan
//   block_in - result block [0:127], byte 0 = bits [0:7]
//   step     - raw push-button level, asynchronous to clk
//   auto_en  - 1 = advance on the dwell timer
//   byte_out - currently selected byte (registered)
//   byte_idx - index of byte_out, 0..15 (registered)
//   busy     - 1 while a block is being shown
//   done     - one-cycle pulse when the scan wraps from byte 15 to 0
module aes_byte_scanner #(
    parameter int unsigned DWELL_CYCLES = 32'd50000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [0:127] block_in,
    input  logic         step,
    input  logic         auto_en,
    output logic [7:0]   byte_out,
    output logic [3:0]   byte_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE,
        SHOW
    } state_e;

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

    state_e       state_q;
    logic [0:127] shadow_q;
    logic [3:0]   idx_q;
    logic [7:0]   byte_q;
    logic [31:0]  cnt_q;
    logic         done_q;

    logic         sync1_q;
    logic         sync2_q;
    logic         hist_q;

    logic         step_pulse;
    logic         expire;
    logic         advance;
    logic [3:0]   idx_d;
    logic [7:0]   byte_d;

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= step;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign step_pulse = sync2_q & ~hist_q;
    assign expire     = auto_en && (cnt_q == DWELL_LAST);
    assign advance    = (state_q == SHOW) && (step_pulse || expire);

    // Next byte is pre-selected so byte_out and byte_idx move together.
    assign idx_d  = idx_q + 4'd1;
    assign byte_d = shadow_q[{idx_d, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                // A capture overrides any coincident advance.
                state_q  <= SHOW;
                shadow_q <= block_in;
                idx_q    <= '0;
                byte_q   <= block_in[0:7];
                cnt_q    <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    SHOW: begin
                        if (advance) begin
                            idx_q  <= idx_d;
                            byte_q <= byte_d;
                            cnt_q  <= '0;
                            done_q <= (idx_q == 4'd15);
                        end else if (auto_en) begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign byte_out = byte_q;
    assign byte_idx = idx_q;
    assign busy     = (state_q == SHOW);
    assign done     = done_q;

endmodule

// File: tb/tb_aes_byte_scanner.sv
// tb_aes_byte_scanner: table-driven and scoreboard checks of the byte
// scanner with a short dwell time.
module tb_aes_byte_scanner;

    localparam int DW = 4;
    localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [0:127] block_in = '0;
    logic         step = 1'b0;
    logic         auto_en = 1'b0;
    logic [7:0]   byte_out;
    logic [3:0]   byte_idx;
    logic         busy;
    logic         done;

    aes_byte_scanner #(.DWELL_CYCLES(DW)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .block_in(block_in),
        .step(step),
        .auto_en(auto_en),
        .byte_out(byte_out),
        .byte_idx(byte_idx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] b;
        logic [3:0] i;
        bit         bz;
        bit         d;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        bit           ld;
        logic [127:0] blk;
        bit           stp;
        bit           aut;
        int           n;
        logic [7:0]   eb;
        logic [3:0]   ei;
        bit           ebz;
    } row_t;

    row_t rows[$];

    // Reference model state
    logic [127:0] m_sh;
    int           m_idx;
    int           m_cnt;
    bit           m_show;
    bit           m_done;
    bit           m_s1, m_s2, m_s3;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic m_reset();
        m_sh = '0; m_idx = 0; m_cnt = 0; m_show = 0; m_done = 0;
        m_s1 = 0; m_s2 = 0; m_s3 = 0;
    endtask

    function automatic logic [7:0] m_byte();
        logic [127:0] t;
        t = m_sh >> (8 * (15 - m_idx));
        return t[7:0];
    endfunction

    // Advance model by one edge using currently driven inputs, push
    // expectation, clock, pop and compare.
    task automatic cycle();
        exp_t e;
        bit pulse, expd;
        if (!rst) begin
            m_reset();
        end else begin
            pulse = m_s2 && !m_s3;
            expd = auto_en && (m_cnt == DW - 1);
            m_done = 0;
            if (load) begin
                m_sh = block_in; m_idx = 0; m_cnt = 0; m_show = 1;
            end else if (m_show && (pulse || expd)) begin
                m_done = (m_idx == 15);
                m_idx = (m_idx + 1) % 16;
                m_cnt = 0;
            end else if (m_show && auto_en) begin
                m_cnt++;
            end
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = step;
        end
        e.b = m_byte(); e.i = 4'(m_idx); e.bz = m_show; e.d = m_done;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("sb_byte", 32'(byte_out), 32'(e.b));
        chk("sb_idx", 32'(byte_idx), 32'(e.i));
        chk("sb_busy", 32'(busy), 32'(e.bz));
        chk("sb_done", 32'(done), 32'(e.d));
    endtask

    task automatic add(bit ld, logic [127:0] blk, bit stp, bit aut, int n,
                       logic [7:0] eb, logic [3:0] ei, bit ebz);
        row_t r;
        r.ld = ld; r.blk = blk; r.stp = stp; r.aut = aut; r.n = n;
        r.eb = eb; r.ei = ei; r.ebz = ebz;
        rows.push_back(r);
    endtask

    task automatic run_row(row_t r, int k);
        load = r.ld; block_in = r.blk; step = r.stp; auto_en = r.aut;
        cycle();
        load = 1'b0;
        repeat (r.n) cycle();
        chk($sformatf("row%0d_byte", k), 32'(byte_out), 32'(r.eb));
        chk($sformatf("row%0d_idx", k), 32'(byte_idx), 32'(r.ei));
        chk($sformatf("row%0d_busy", k), 32'(busy), 32'(r.ebz));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        // manual stepping
        add(1, B1, 0, 0, 0, 8'h00, 4'd0, 1);
        add(0, B1, 1, 0, 2, 8'h11, 4'd1, 1);
        add(0, B1, 0, 0, 2, 8'h11, 4'd1, 1);
        add(0, B1, 1, 0, 2, 8'h22, 4'd2, 1);
        add(0, B1, 0, 0, 2, 8'h22, 4'd2, 1);
        add(0, B1, 1, 0, 9, 8'h33, 4'd3, 1);
        add(0, B1, 0, 0, 2, 8'h33, 4'd3, 1);
        // auto dwell
        add(1, B1, 0, 1, 0, 8'h00, 4'd0, 1);
        add(0, B1, 0, 1, 3, 8'h11, 4'd1, 1);
        add(0, B1, 0, 1, 3, 8'h22, 4'd2, 1);
        add(0, B1, 0, 1, 51, 8'hff, 4'd15, 1);
        // dwell pause
        add(1, B1, 0, 1, 0, 8'h00, 4'd0, 1);
        add(0, B1, 0, 1, 1, 8'h00, 4'd0, 1);
        add(0, B1, 0, 0, 5, 8'h00, 4'd0, 1);
        add(0, B1, 0, 1, 0, 8'h00, 4'd0, 1);
        add(0, B1, 0, 1, 0, 8'h11, 4'd1, 1);

        // reset then idle activity
        repeat (5) cycle();
        rst = 1'b1;
        auto_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step = (k % 4) < 2;
            cycle();
        end
        chk("idle_byte", 32'(byte_out), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        step = 1'b0; auto_en = 1'b0;
        repeat (4) cycle();

        // table: rows 0-10 before wrap check, remainder after
        for (int k = 0; k < 11; k++) run_row(rows[k], k);

        // wrap from 15 to 0
        repeat (3) cycle();
        chk("wrap_pre_idx", 32'(byte_idx), 32'd15);
        chk("wrap_pre_done", 32'(done), 32'd0);
        cycle();
        chk("wrap_idx", 32'(byte_idx), 32'd0);
        chk("wrap_byte", 32'(byte_out), 32'h00);
        chk("wrap_done", 32'(done), 32'd1);
        cycle();
        chk("wrap_post_done", 32'(done), 32'd0);

        for (int k = 11; k < rows.size(); k++) run_row(rows[k], k);

        // reload coincident with step pulse at idx 9
        load = 1'b1; block_in = B1; auto_en = 1'b1;
        cycle();
        load = 1'b0;
        repeat (36) cycle();
        chk("rl_pre_idx", 32'(byte_idx), 32'd9);
        chk("rl_pre_byte", 32'(byte_out), 32'h99);
        auto_en = 1'b0; step = 1'b1;
        cycle();
        cycle();
        load = 1'b1; block_in = B2;
        cycle();
        load = 1'b0; step = 1'b0;
        chk("rl_idx", 32'(byte_idx), 32'd0);
        chk("rl_byte", 32'(byte_out), 32'h69);
        chk("rl_done", 32'(done), 32'd0);
        auto_en = 1'b1;
        repeat (3) cycle();
        chk("rl_dwell_hold", 32'(byte_idx), 32'd0);
        cycle();
        chk("rl_dwell_idx", 32'(byte_idx), 32'd1);
        chk("rl_dwell_byte", 32'(byte_out), 32'hc4);

        // asynchronous reset at idx 7
        load = 1'b1; block_in = B1;
        cycle();
        load = 1'b0;
        repeat (28) cycle();
        chk("ar_pre_idx", 32'(byte_idx), 32'd7);
        chk("ar_pre_byte", 32'(byte_out), 32'h77);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_byte", 32'(byte_out), 32'h0);
        chk("ar_idx", 32'(byte_idx), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        m_reset();
        @(posedge clk); #1;
        repeat (2) cycle();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step = (k % 4) < 2;
            cycle();
        end
        chk("ar_post_busy", 32'(busy), 32'h0);
        step = 1'b0; auto_en = 1'b0;
        repeat (3) cycle();
        load = 1'b1; block_in = B2;
        cycle();
        load = 1'b0;
        chk("ar_reload_byte", 32'(byte_out), 32'h69);
        chk("ar_reload_busy", 32'(busy), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
